// File: rtl/wb_burst_slave_if_if.sv
// Wishbone burst slave-port bundle: the master drives address/data/strobes,
// the slave returns read data and the per-beat ack/lack/err pulses.
interface wb_burst_slave_if_if;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [9:0]  wbs_bl_i;
  logic        wbs_bry_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_lack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
  );

  modport slave (
    input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_burst_slave_if.sv
// Wishbone single/burst slave bridged onto a one-outstanding SRAM-style
// req/gnt/rvalid memory port, with address wrap and out-of-range error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cyc&stb; blocked while an aborted read is pending
// WR_REQ  | issuing write beats; skips the cycle its ack is visible
// RD_REQ  | issuing a read request for the current beat
// RD_WAIT | read granted, waiting for rvalid
// RD_ACK  | read data held on wbs_dat_o until bry lets the beat complete
// ERR     | out-of-range transfer; single ack+lack+err, no memory access
// DONE    | one dead cycle to absorb the master dropping stb
module wb_burst_slave_if #(
  parameter int unsigned AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  wb_burst_slave_if_if.slave    wb,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_ACK  = 3'd4,
    ERR     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [9:0]    cnt;
  logic [31:0]   dat_q;
  logic          ack_q, lack_q, err_q;
  logic          pend;

  logic ack_set, lack_set, err_set;
  logic start, addr_inc, cnt_dec, rd_cap, pend_set, pend_clr;
  logic in_range, last_beat, req;
  logic unused_adr_lsb;

  assign in_range       = (wb.wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign last_beat      = (cnt == 10'd1);
  assign unused_adr_lsb = ^wb.wbs_adr_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    ack_set   = 1'b0;
    lack_set  = 1'b0;
    err_set   = 1'b0;
    start     = 1'b0;
    addr_inc  = 1'b0;
    cnt_dec   = 1'b0;
    rd_cap    = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          pend_clr = mem_rvalid_i;
        end else if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
          start = 1'b1;
          if (!in_range)          state_nxt = ERR;
          else if (wb.wbs_we_i)   state_nxt = WR_REQ;
          else                    state_nxt = RD_REQ;
        end
      end
      WR_REQ: begin
        if (!wb.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else begin
          // ack_q marks the cycle the master is still presenting the old beat
          req = wb.wbs_stb_i && wb.wbs_bry_i && !ack_q;
          if (req && mem_gnt_i) begin
            ack_set  = 1'b1;
            lack_set = last_beat;
            addr_inc = 1'b1;
            cnt_dec  = 1'b1;
            if (last_beat) state_nxt = DONE;
          end
        end
      end
      RD_REQ: begin
        if (!wb.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else begin
          req = wb.wbs_stb_i && wb.wbs_bry_i;
          if (req && mem_gnt_i) begin
            addr_inc  = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (wb.wbs_cyc_i) begin
            rd_cap    = 1'b1;
            state_nxt = RD_ACK;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!wb.wbs_cyc_i) begin
          pend_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_ACK: begin
        if (!wb.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (wb.wbs_stb_i && wb.wbs_bry_i) begin
          ack_set   = 1'b1;
          lack_set  = last_beat;
          cnt_dec   = 1'b1;
          state_nxt = last_beat ? DONE : RD_REQ;
        end
      end
      ERR: begin
        if (!wb.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else begin
          ack_set   = 1'b1;
          lack_set  = 1'b1;
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      cnt    <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      lack_q <= 1'b0;
      err_q  <= 1'b0;
      pend   <= 1'b0;
    end else begin
      ack_q  <= ack_set;
      lack_q <= lack_set;
      err_q  <= err_set;
      if (start) begin
        addr <= wb.wbs_adr_i[AW+1:2];
        cnt  <= (wb.wbs_bl_i == 10'd0) ? 10'd1 : wb.wbs_bl_i;
      end else begin
        if (addr_inc) addr <= addr + AW'(1);
        if (cnt_dec)  cnt  <= cnt - 10'd1;
      end
      if (rd_cap) dat_q <= mem_rdata_i;
      if (pend_set)      pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
    end
  end

  assign mem_req_o   = req;
  assign mem_we_o    = (state == WR_REQ);
  assign mem_addr_o  = addr;
  assign mem_wdata_o = (state == WR_REQ) ? wb.wbs_dat_i : 32'h0;
  assign mem_be_o    = (state == WR_REQ) ? wb.wbs_sel_i : 4'h0;

  assign wb.wbs_dat_o  = dat_q;
  assign wb.wbs_ack_o  = ack_q;
  assign wb.wbs_lack_o = lack_q;
  assign wb.wbs_err_o  = err_q;

endmodule

// File: tb/tb_wb_burst_slave_if.sv
// Scoreboard bench for wb_burst_slave_if: expected acks and memory accesses
// are queued when a transfer is launched and retired by negedge monitors.
module tb_wb_burst_slave_if;
  localparam int AW = 10;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  wb_burst_slave_if_if bus ();

  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  wb_burst_slave_if #(.AW(AW), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .wb           (bus.slave),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // memory: grants immediately, returns 0x100+addr two cycles after a read grant
  logic [1:0]    rd_dly;
  logic [AW-1:0] rd_addr;
  assign mem_gnt    = mem_req;
  assign mem_rvalid = (rd_dly == 2'd1);
  assign mem_rdata  = 32'h100 + 32'(rd_addr);

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_dly  <= 2'd0;
      rd_addr <= '0;
    end else if (mem_req && mem_gnt && !mem_we) begin
      rd_dly  <= 2'd2;
      rd_addr <= mem_addr;
    end else if (rd_dly != 2'd0) begin
      rd_dly <= rd_dly - 2'd1;
    end
  end

  typedef struct {
    logic [31:0] dat;
    logic        lack;
    logic        err;
    logic        chk_dat;
  } ack_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } mem_exp_t;

  ack_exp_t ack_sb[$];
  mem_exp_t mem_sb[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  logic     no_req  = 1'b0;
  logic     wr_gnt_d = 1'b0;
  ack_exp_t mon_a;
  mem_exp_t mon_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_n) begin
      wr_gnt_d = 1'b0;
    end else begin
      if (no_req) check_eq("no_req", 32'(mem_req), 32'h0);
      if (wr_gnt_d) check_eq("wr_ack_lat", 32'(bus.wbs_ack_o), 32'h1);
      wr_gnt_d = mem_req && mem_gnt && mem_we;
      if (mem_req && mem_gnt) begin
        if (mem_sb.size() == 0) begin
          check_eq("mem_unexp", 32'(mem_req), 32'h0);
        end else begin
          mon_m = mem_sb.pop_front();
          check_eq("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
          check_eq("mem_we", 32'(mem_we), 32'(mon_m.we));
          if (mon_m.we) begin
            check_eq("mem_wdata", mem_wdata, mon_m.wdata);
            check_eq("mem_be", 32'(mem_be), 32'(mon_m.be));
          end
        end
      end
      if (bus.wbs_ack_o) begin
        if (ack_sb.size() == 0) begin
          check_eq("ack_unexp", 32'(bus.wbs_ack_o), 32'h0);
        end else begin
          mon_a = ack_sb.pop_front();
          check_eq("lack", 32'(bus.wbs_lack_o), 32'(mon_a.lack));
          check_eq("err", 32'(bus.wbs_err_o), 32'(mon_a.err));
          if (mon_a.chk_dat) check_eq("rd_dat", bus.wbs_dat_o, mon_a.dat);
        end
      end else if (bus.wbs_lack_o || bus.wbs_err_o) begin
        check_eq("lack_err_no_ack", {30'h0, bus.wbs_lack_o, bus.wbs_err_o}, 32'h0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"},   32'(bus.wbs_ack_o),  32'h0);
    check_eq({tag, "_lack"},  32'(bus.wbs_lack_o), 32'h0);
    check_eq({tag, "_err"},   32'(bus.wbs_err_o),  32'h0);
    check_eq({tag, "_dat"},   bus.wbs_dat_o,       32'h0);
    check_eq({tag, "_req"},   32'(mem_req),        32'h0);
    check_eq({tag, "_we"},    32'(mem_we),         32'h0);
    check_eq({tag, "_addr"},  32'(mem_addr),       32'h0);
    check_eq({tag, "_wdata"}, mem_wdata,           32'h0);
    check_eq({tag, "_be"},    32'(mem_be),         32'h0);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input int bl,
                         input logic [31:0] wbase, input logic [3:0] sel,
                         input int abort_after, input int stall_beat);
    int            n, beats, cycles, stall_left;
    bit            done, stalled, oor;
    logic [AW-1:0] word, stall_word;
    ack_exp_t      a;
    mem_exp_t      m;
    word = adr[AW+1:2];
    oor  = (adr[31:AW+2] != '0);
    n    = (bl == 0) ? 1 : bl;
    if (abort_after > 0) n = abort_after;
    if (oor) begin
      n = 1;
      a = '{dat: 32'h0, lack: 1'b1, err: 1'b1, chk_dat: 1'b0};
      ack_sb.push_back(a);
      no_req = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        m.addr  = word + AW'(i);
        m.we    = we;
        m.wdata = wbase + 32'(i);
        m.be    = sel;
        mem_sb.push_back(m);
        a.dat     = 32'h100 + 32'(m.addr);
        a.lack    = (abort_after == 0) && (i == n - 1);
        a.err     = 1'b0;
        a.chk_dat = !we;
        ack_sb.push_back(a);
      end
    end
    stall_word = word + AW'(stall_beat);
    bus.wbs_adr_i = adr;
    bus.wbs_bl_i  = 10'(bl);
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = we ? wbase : 32'h0;
    bus.wbs_bry_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    beats = 0; cycles = 0; stall_left = 0; done = 0; stalled = 0;
    while (!done && cycles < 200) begin
      @(negedge clk_i);
      cycles++;
      if (!bus.wbs_bry_i) begin
        check_eq("stall_dat", bus.wbs_dat_o, 32'h100 + 32'(stall_word));
        check_eq("stall_ack", 32'(bus.wbs_ack_o), 32'h0);
      end
      if (bus.wbs_ack_o) begin
        beats++;
        if (bus.wbs_lack_o) done = 1;
      end
      if (stall_beat > 0 && !stalled && mem_rvalid && beats == stall_beat) begin
        stall_left = 3;
        stalled    = 1;
      end
      @(posedge clk_i);
      #1;
      if (abort_after > 0 && beats == abort_after) begin
        done   = 1;
        no_req = 1'b1;
      end
      bus.wbs_bry_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (we) bus.wbs_dat_i = wbase + 32'(beats);
    end
    check_eq("beats", 32'(beats), 32'(n));
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_bry_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    no_req = 1'b0;
  endtask

  initial begin
    mem_exp_t m;
    bit       seen;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_sel_i = '0;
    bus.wbs_bl_i  = '0;
    bus.wbs_bry_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs_zero("rst");
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    wb_xfer(1'b1, 32'h0000_0010, 1, 32'hA5A5_0001, 4'hF, 0, 0);
    wb_xfer(1'b0, 32'h0000_0020, 4, 32'h0,         4'hF, 0, 0);
    wb_xfer(1'b0, 32'h0000_0FF8, 3, 32'h0,         4'hF, 0, 0);
    wb_xfer(1'b0, 32'h0000_0040, 4, 32'h0,         4'hF, 0, 1);
    wb_xfer(1'b1, 32'h8000_0000, 2, 32'h0BAD_0000, 4'hF, 0, 0);
    wb_xfer(1'b1, 32'h0000_0030, 0, 32'hDEAD_0000, 4'h3, 0, 0);
    wb_xfer(1'b1, 32'h0000_0FFC, 3, 32'h1234_0000, 4'hC, 0, 0);
    wb_xfer(1'b1, 32'h0000_0050, 8, 32'h5555_0000, 4'hF, 1, 0);

    // read left waiting for rvalid, then hit with async reset
    m = '{addr: AW'(32), we: 1'b0, wdata: 32'h0, be: 4'h0};
    mem_sb.push_back(m);
    bus.wbs_adr_i = 32'h0000_0080;
    bus.wbs_bl_i  = 10'd2;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_bry_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk_i);
      seen = mem_req && mem_gnt;
    end
    check_eq("rst_rd_gnt", 32'(seen), 32'h1);
    @(posedge clk_i);
    #1;
    rst_n = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    wb_xfer(1'b1, 32'h0000_0100, 2, 32'hCAFE_0000, 4'hF, 0, 0);
    wb_xfer(1'b0, 32'h0000_0200, 2, 32'h0,         4'hF, 0, 0);

    check_eq("ack_sb_left", 32'(ack_sb.size()), 32'h0);
    check_eq("mem_sb_left", 32'(mem_sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_burst_slave_if.md
Name: wb_burst_slave_if

Overview:
- Terminates the slave side of the staged wishbone interconnect port, i.e. the s_wbd_* bus: adr, dat, sel, bl, bry, we, cyc, stb toward the slave; dat, ack, lack back to the master.
- Converts single and burst wishbone transfers into a simple one-outstanding SRAM-style request/grant/rvalid interface.
- Generates per-beat ack, last-beat lack, address auto-increment and out-of-range error.
- Sits between an interconnect slave port and an on-chip memory or register bank.

Parameters:
- AW, 10, memory word-address width; a burst wraps within 2^AW words.
- BASE_ADDR, 32'h0000_0000, region base; a transfer is in range when adr[31:AW+2] == BASE_ADDR[31:AW+2].

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address; bits [1:0] ignored.
- wbs_sel_i  in  4  byte enables.
- wbs_bl_i  in  10  burst length in words; 0 is treated as 1.
- wbs_bry_i  in  1  master burst-ready; a beat proceeds only while high.
- wbs_we_i  in  1  1=write, 0=read.
- wbs_cyc_i  in  1  cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_dat_o  out  32  read data, registered.
- wbs_ack_o  out  1  beat acknowledge, one-cycle pulse.
- wbs_lack_o  out  1  last-beat acknowledge, coincident with the final ack.
- wbs_err_o  out  1  error pulse, coincident with ack and lack.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  AW  memory word address.
- mem_wdata_o  out  32  write data.
- mem_be_o  out  4  byte enables.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; at most one per granted read, arrives ≥1 cycle after gnt.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; beat counter and address register 0.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_ACK, ERR, DONE.
- IDLE, on cyc&stb:
  - latch adr[AW+1:2] into addr, latch we, set cnt = (bl==0)?1:bl.
  - out of range -> ERR.
  - else we=1 -> WR_REQ, we=0 -> RD_REQ.
- WR_REQ:
  - mem_req_o = stb&bry. mem_addr_o=addr; mem_wdata_o=wbs_dat_i and mem_be_o=wbs_sel_i, both driven combinationally from the current beat.
  - On mem_gnt_i: register wbs_ack_o=1 for the next cycle only; wbs_lack_o=1 too if cnt==1.
  - Then cnt-1 and addr+1, wrapping modulo 2^AW.
  - cnt==1 -> DONE; else stay in WR_REQ and ignore the beat in the cycle the ack is visible, so the master can advance data. Minimum 2 cycles per write beat.
- RD_REQ:
  - mem_req_o=1 while bry high (mem_we_o=0).
  - On gnt -> RD_WAIT; addr+1 with wrap.
- RD_WAIT:
  - On mem_rvalid_i, capture mem_rdata_i into wbs_dat_o -> RD_ACK.
- RD_ACK:
  - If bry=1: ack=1 for one cycle (lack too if cnt==1); cnt-1. cnt==1 -> DONE, else -> RD_REQ.
  - If bry=0: hold in RD_ACK; wbs_dat_o stays stable.
- ERR: ack=lack=err=1 for one cycle, no memory access -> DONE.
- DONE: one cycle with stb ignored, to absorb the master's stb deassert latency -> IDLE.
- Next transfer start: IDLE sees a new stb in the cycle after DONE at the earliest.
- wbs_dat_o holds its last value outside read acks.
- cyc dropped in any non-IDLE state:
  - go to IDLE next cycle; no further mem_req_o and no ack.
  - A pending mem_rvalid_i for an already-granted read is consumed and discarded; the next transfer must not start until it arrives. Add a 1-bit pending flag.
  - stb low with cyc high pauses the burst (no req) without aborting.
- Asynchronous reset mid-burst: immediate return to reset values; the outstanding memory read is dropped.
- Never more than one mem_req outstanding; mem_req_o is never asserted in RD_WAIT, RD_ACK, ERR or DONE.

Test Plan:
- Single write, adr=0x10, dat=0xA5A5_0001, sel=4'hF, bl=1, gnt same cycle -> mem_addr_o=4, mem_we_o=1; one ack with lack=1 on the following cycle; err=0.
- Read burst bl=4 from adr=0x20, rvalid 2 cycles after each gnt, memory holds 0x100+addr -> wbs_dat_o sequence 0x108,0x109,0x10A,0x10B; four acks; lack only on the 4th.
- Wrap: AW=10, read bl=3 at word 1022 -> mem_addr_o 1022,1023,0.
- bry low for 3 cycles during read beat 2 -> ack withheld; wbs_dat_o stable; beat completes once bry returns high; total 4 acks.
- Out-of-range adr=0x8000_0000 with BASE_ADDR=0 -> ack=lack=err=1 for one cycle; mem_req_o never asserted.
- cyc dropped after beat 1 of a bl=8 write, then reset asserted during a later read in RD_WAIT -> no further mem_req after the abort; all outputs 0 immediately on reset; the next transfer completes normally.
